// File: rtl/pool_stream.sv
// pool_stream: streaming non-overlapping POOL_SIZE x POOL_SIZE pooling engine.
// Pixels arrive in raster order with all channels packed into one beat. Each
// window is reduced horizontally in a per-channel accumulator. Partial window
// results are folded vertically through a row buffer that holds one entry per
// output column.
// Optional feature macro POOL_AVG_EN: when it is defined, the average datapath is
// compiled in and the mode input selects max (0) or average (1). When it is
// undefined, the engine always computes max.
module pool_stream #(
  parameter int DATA_WIDTH   = 8,
  parameter int CHANNELS     = 1,
  parameter int IFMAP_WIDTH  = 32,
  parameter int IFMAP_HEIGHT = 32,
  parameter int POOL_SIZE    = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           mode,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CHANNELS*DATA_WIDTH-1:0] out_data,
  output logic                           busy,
  output logic                           done
);

  localparam int LOG2P   = $clog2(POOL_SIZE);
  localparam int OFMAP_W = IFMAP_WIDTH / POOL_SIZE;
  localparam int OFMAP_H = IFMAP_HEIGHT / POOL_SIZE;
  // One spare bit on the counters keeps the row-buffer index slice in range
  // even when the image is exactly one window wide.
  localparam int COL_W   = $clog2(IFMAP_WIDTH + 1);
  localparam int ROW_W   = $clog2(IFMAP_HEIGHT + 1);
  localparam int ADDR_W  = (OFMAP_W > 1) ? $clog2(OFMAP_W) : 1;
  localparam int DEPTH   = 1 << ADDR_W;
`ifdef POOL_AVG_EN
  localparam int ACC_W   = DATA_WIDTH + 2 * LOG2P;
`else
  localparam int ACC_W   = DATA_WIDTH;
`endif

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                         state_reg, state_next;
  logic                           done_reg, done_next;
  logic [COL_W-1:0]               in_col_reg;
  logic [ROW_W-1:0]               in_row_reg;
  logic                           out_valid_reg;
  logic [CHANNELS*DATA_WIDTH-1:0] out_data_reg;

  logic [CHANNELS*ACC_W-1:0]      h_acc_reg, rb_q_reg;
  logic [CHANNELS*ACC_W-1:0]      pix_ext, h_comb, row_val;
  logic [CHANNELS*DATA_WIDTH-1:0] pool_res;
  logic [CHANNELS*ACC_W-1:0]      row_buf [DEPTH];

  logic             accept, in_win, last_pix, emit;
  logic [LOG2P-1:0] win_col, win_row;
  logic [ADDR_W-1:0] rb_idx;

`ifdef POOL_AVG_EN
  logic avg_mode_reg;

  // Capture the reduction mode at frame start; it holds for the whole frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         avg_mode_reg <= 1'b0;
    else if (state_reg == IDLE && start) avg_mode_reg <= mode;
  end

  function automatic logic [ACC_W-1:0] combine(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
    return avg_mode_reg ? (a + b) : ((a > b) ? a : b);
  endfunction
`else
  logic unused_mode;
  assign unused_mode = mode;

  function automatic logic [ACC_W-1:0] combine(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
    return (a > b) ? a : b;
  endfunction
`endif

  assign in_ready  = (state_reg == RUN) && (!out_valid_reg || out_ready);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

  assign win_col  = in_col_reg[LOG2P-1:0];
  assign win_row  = in_row_reg[LOG2P-1:0];
  assign rb_idx   = in_col_reg[LOG2P +: ADDR_W];
  assign in_win   = (in_col_reg < COL_W'(OFMAP_W * POOL_SIZE)) &&
                    (in_row_reg < ROW_W'(OFMAP_H * POOL_SIZE));
  assign last_pix = (in_col_reg == COL_W'(IFMAP_WIDTH - 1)) &&
                    (in_row_reg == ROW_W'(IFMAP_HEIGHT - 1));
  assign emit     = accept && in_win && (&win_col) && (&win_row);

  // Per-channel reduction: horizontal fold, vertical fold against the row
  // buffer (the first window row passes straight through), final scaling.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    assign pix_ext[gi*ACC_W +: ACC_W] = ACC_W'(in_data[gi*DATA_WIDTH +: DATA_WIDTH]);
    assign h_comb[gi*ACC_W +: ACC_W]  = combine(h_acc_reg[gi*ACC_W +: ACC_W],
                                                pix_ext[gi*ACC_W +: ACC_W]);
    assign row_val[gi*ACC_W +: ACC_W] = (win_row == '0) ? h_comb[gi*ACC_W +: ACC_W] :
                                        combine(rb_q_reg[gi*ACC_W +: ACC_W],
                                                h_comb[gi*ACC_W +: ACC_W]);
`ifdef POOL_AVG_EN
    assign pool_res[gi*DATA_WIDTH +: DATA_WIDTH] = avg_mode_reg ?
        DATA_WIDTH'(row_val[gi*ACC_W +: ACC_W] >> (2 * LOG2P)) :
        row_val[gi*ACC_W +: DATA_WIDTH];
`else
    assign pool_res[gi*DATA_WIDTH +: DATA_WIDTH] = row_val[gi*ACC_W +: DATA_WIDTH];
`endif
  end

  // Accumulator and row buffer. The buffer entry for a window is read at the
  // window's first column, so its registered read is ready by the last column.
  always_ff @(posedge clk) begin
    if (accept && in_win) begin
      if (win_col == '0) begin
        h_acc_reg <= pix_ext;
        rb_q_reg  <= row_buf[rb_idx];
      end else begin
        h_acc_reg <= h_comb;
      end
      if (&win_col) row_buf[rb_idx] <= row_val;
    end
  end

  // State register, done pulse and raster position counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      done_reg   <= 1'b0;
      in_col_reg <= '0;
      in_row_reg <= '0;
    end else begin
      state_reg <= state_next;
      done_reg  <= done_next;
      if (state_reg == IDLE && start) begin
        in_col_reg <= '0;
        in_row_reg <= '0;
      end else if (accept) begin
        if (in_col_reg == COL_W'(IFMAP_WIDTH - 1)) begin
          in_col_reg <= '0;
          in_row_reg <= (in_row_reg == ROW_W'(IFMAP_HEIGHT - 1)) ? '0 : in_row_reg + 1'b1;
        end else begin
          in_col_reg <= in_col_reg + 1'b1;
        end
      end
    end
  end

  // Output register: load on a completed window, clear once downstream takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (emit) begin
      out_valid_reg <= 1'b1;
      out_data_reg  <= pool_res;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  // Frame sequencing. FLUSH waits for any pending output to be accepted.
  always_comb begin
    state_next = state_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (accept && last_pix) state_next = FLUSH;
      FLUSH: begin
        if (!out_valid_reg || out_ready) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pool_stream.sv
// Self-checking bench for pool_stream: a 4x4 two-channel instance and a 5x5
// two-channel instance. Expected pooled pixels come from a whole-frame window
// model and are queued when a frame is launched, then popped on each output
// handshake.
module tb_pool_stream;

`ifdef POOL_AVG_EN
  localparam bit AVG_BUILT = 1'b1;
`else
  localparam bit AVG_BUILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start_s    [2];
  logic        mode_s     [2];
  logic        in_valid_s [2];
  logic        out_ready_s[2];
  logic [15:0] in_data_s  [2];
  wire         in_ready_w [2];
  wire         out_valid_w[2];
  wire         busy_w     [2];
  wire         done_w     [2];
  wire  [15:0] out_data_w [2];

  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] frame_q[$];
  int          done_cnt, cur_idx, cur_n;
  bit          done_due, hold_active;
  logic [15:0] held_data;

  always #5 clk = ~clk;

  pool_stream #(.DATA_WIDTH(8), .CHANNELS(2), .IFMAP_WIDTH(4), .IFMAP_HEIGHT(4), .POOL_SIZE(2)) u_dut4 (
    .clk(clk), .reset(reset), .start(start_s[0]), .mode(mode_s[0]),
    .in_valid(in_valid_s[0]), .in_ready(in_ready_w[0]), .in_data(in_data_s[0]),
    .out_valid(out_valid_w[0]), .out_ready(out_ready_s[0]), .out_data(out_data_w[0]),
    .busy(busy_w[0]), .done(done_w[0])
  );

  pool_stream #(.DATA_WIDTH(8), .CHANNELS(2), .IFMAP_WIDTH(5), .IFMAP_HEIGHT(5), .POOL_SIZE(2)) u_dut5 (
    .clk(clk), .reset(reset), .start(start_s[1]), .mode(mode_s[1]),
    .in_valid(in_valid_s[1]), .in_ready(in_ready_w[1]), .in_data(in_data_s[1]),
    .out_valid(out_valid_w[1]), .out_ready(out_ready_s[1]), .out_data(out_data_w[1]),
    .busy(busy_w[1]), .done(done_w[1])
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Window model over the stored frame: ch0 in [7:0], ch1 in [15:8].
  task automatic push_expected(input int d, input bit mode);
    int w = (d == 0) ? 4 : 5;
    bit avg = mode && AVG_BUILT;
    for (int wr = 0; wr < w / 2; wr++) begin
      for (int wc = 0; wc < w / 2; wc++) begin
        logic [15:0] e = '0;
        for (int c = 0; c < 2; c++) begin
          int mx = 0;
          int sum = 0;
          for (int dy = 0; dy < 2; dy++) begin
            for (int dx = 0; dx < 2; dx++) begin
              logic [15:0] b = frame_q[(2 * wr + dy) * w + 2 * wc + dx];
              int v = int'(b[c*8 +: 8]);
              sum += v;
              if (v > mx) mx = v;
            end
          end
          e[c*8 +: 8] = avg ? 8'(sum >> 2) : 8'(mx);
        end
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic fill_ramp(input int n);
    frame_q.delete();
    for (int i = 0; i < n; i++) frame_q.push_back({8'(n - 1 - i), 8'(i)});
  endtask

  // One clock: sample just after the falling edge, then advance to the next one.
  task automatic step(input int d, output bit acc);
    logic [15:0] e;
    #1;
    acc = in_valid_s[d] && in_ready_w[d];
    if (hold_active) begin
      check_eq("bp_in_ready", 32'(in_ready_w[d]), 0);
      check_eq("bp_hold", 32'(out_data_w[d]), 32'(held_data));
    end
    if (done_due) begin
      check_eq("done_timing", 32'(done_w[d]), 1);
      done_due = 1'b0;
    end
    if (done_w[d]) begin
      done_cnt++;
      check_eq("busy_low_at_done", 32'(busy_w[d]), 0);
    end
    if (out_valid_w[d] && out_ready_s[d]) begin
      check_eq("sb_nonempty", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("dut%0d out=%h exp=%h t=%0t", d, out_data_w[d], e, $time);
        check_eq("out_data", 32'(out_data_w[d]), 32'(e));
        if (exp_q.size() == 0 && cur_idx == cur_n) done_due = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_frame(input int d, input bit mode, input bit bp);
    bit acc;
    int hold_left = 0;
    bit held = 1'b0;
    cur_n = frame_q.size();
    cur_idx = 0;
    done_cnt = 0;
    done_due = 1'b0;
    hold_active = 1'b0;
    push_expected(d, mode);
    start_s[d] = 1'b1;
    mode_s[d] = mode;
    out_ready_s[d] = 1'b1;
    in_valid_s[d] = 1'b0;
    step(d, acc);
    start_s[d] = 1'b0;
    check_eq("busy_run", 32'(busy_w[d]), 1);
    for (int cyc = 0; cyc < 400 && done_cnt == 0; cyc++) begin
      if (bp && !held && out_valid_w[d]) begin
        held = 1'b1;
        hold_left = 5;
        held_data = out_data_w[d];
      end
      hold_active = (hold_left > 0);
      out_ready_s[d] = hold_active ? 1'b0 : (bp ? 1'($urandom_range(0, 1)) : 1'b1);
      in_valid_s[d] = (cur_idx < cur_n);
      in_data_s[d] = (cur_idx < cur_n) ? frame_q[cur_idx] : 16'h0;
      step(d, acc);
      if (acc) cur_idx++;
      if (hold_left > 0) hold_left--;
    end
    hold_active = 1'b0;
    in_valid_s[d] = 1'b0;
    out_ready_s[d] = 1'b1;
    check_eq("frame_done", 32'(done_cnt), 1);
    step(d, acc);
    step(d, acc);
    check_eq("done_once", 32'(done_cnt), 1);
    check_eq("sb_drained", 32'(exp_q.size()), 0);
    check_eq("inputs_taken", 32'(cur_idx), 32'(cur_n));
  endtask

  // Start a frame, push 6 beats with the output stalled, then reset mid-frame.
  task automatic abort_frame();
    bit acc;
    int k = 0;
    cur_n = 0;
    cur_idx = 0;
    fill_ramp(16);
    start_s[0] = 1'b1;
    mode_s[0] = 1'b0;
    out_ready_s[0] = 1'b0;
    in_valid_s[0] = 1'b0;
    step(0, acc);
    start_s[0] = 1'b0;
    for (int cyc = 0; cyc < 20 && k < 6; cyc++) begin
      in_valid_s[0] = 1'b1;
      in_data_s[0] = frame_q[k];
      step(0, acc);
      if (acc) k++;
    end
    in_valid_s[0] = 1'b0;
    check_eq("abort_beats", 32'(k), 6);
    check_eq("pre_reset_valid", 32'(out_valid_w[0]), 1);
    reset = 1'b1;
    #1;
    check_eq("mid_rst_in_ready", 32'(in_ready_w[0]), 0);
    check_eq("mid_rst_out_valid", 32'(out_valid_w[0]), 0);
    check_eq("mid_rst_out_data", 32'(out_data_w[0]), 0);
    check_eq("mid_rst_busy", 32'(busy_w[0]), 0);
    check_eq("mid_rst_done", 32'(done_w[0]), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    out_ready_s[0] = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0;
      mode_s[d] = 1'b0;
      in_valid_s[d] = 1'b0;
      out_ready_s[d] = 1'b0;
      in_data_s[d] = 16'h0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_eq("rst_in_ready", 32'(in_ready_w[d]), 0);
      check_eq("rst_out_valid", 32'(out_valid_w[d]), 0);
      check_eq("rst_out_data", 32'(out_data_w[d]), 0);
      check_eq("rst_busy", 32'(busy_w[d]), 0);
      check_eq("rst_done", 32'(done_w[d]), 0);
    end
    reset = 1'b0;
    @(negedge clk);

    fill_ramp(16);
    run_frame(0, 1'b0, 1'b0);

    fill_ramp(16);
    run_frame(0, 1'b1, 1'b0);

    frame_q.delete();
    for (int i = 0; i < 16; i++) frame_q.push_back(16'($urandom));
    run_frame(0, 1'b0, 1'b1);

    abort_frame();
    fill_ramp(16);
    run_frame(0, 1'b0, 1'b0);

    fill_ramp(25);
    run_frame(1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pool_stream.md
# pool_stream

Streaming, parametrised 2D pooling engine that replaces the whole-frame, array-ported pooling stage in the CNN datapath. It accepts ifmap pixels in raster order over a valid/ready stream, with all channels packed into one beat. It reduces non-overlapping POOL_SIZE x POOL_SIZE windows (stride = POOL_SIZE) using a row buffer of partial results, and emits ofmap pixels in raster order over a second valid/ready stream. It sits between the convolution/ReLU output stream and the next layer's input buffer.

## Interface
- DATA_WIDTH, 8, unsigned pixel width per channel
- CHANNELS, 1, channels packed per beat; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]
- IFMAP_WIDTH, 32, input columns; must be >= POOL_SIZE
- IFMAP_HEIGHT, 32, input rows; must be >= POOL_SIZE
- POOL_SIZE, 2, window edge and stride; power of two, >= 2

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE
- mode  in  1  0 = max, 1 = average (see Configuration)
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  CHANNELS*DATA_WIDTH  input pixel, all channels
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  CHANNELS*DATA_WIDTH  pooled pixel
- busy  out  1  high in RUN and FLUSH
- done  out  1  one-cycle pulse after the last output beat is accepted

## Operation
- States: IDLE -> (start) RUN -> (last input pixel accepted) FLUSH -> (last output accepted) IDLE, pulsing done on that transition. start is ignored outside IDLE. mode is sampled on start and held for the frame.
- Counters in_col 0..IFMAP_WIDTH-1 and in_row 0..IFMAP_HEIGHT-1 advance on each accepted beat and wrap col->row. Counters reset to 0 on start.
- OFMAP_W = IFMAP_WIDTH/POOL_SIZE and OFMAP_H = IFMAP_HEIGHT/POOL_SIZE (floor). Pixels with in_col >= OFMAP_W*POOL_SIZE or in_row >= OFMAP_H*POOL_SIZE are accepted and discarded.
- Horizontal accumulator per channel: loaded at the first column of a window, combined for the remaining POOL_SIZE-1 columns. At the last window column, the result is written into (or combined with) row_buf[in_col/POOL_SIZE]. The first window row overwrites the buffer entry.
- On the last row and last column of a window, the final combined value is registered into out_data with out_valid=1.
- Max: unsigned compare. Average: accumulator width DATA_WIDTH + 2*log2(POOL_SIZE). The result is the sum >> 2*log2(POOL_SIZE), truncated toward zero, with no rounding.
- Channels are independent. There is no cross-channel interaction.
- in_ready = (state==RUN) && (!out_valid || out_ready). This guarantees at most one pending output and no overflow.

## Timing
- Reset values: in_ready 0, out_valid 0, out_data 0, busy 0, done 0. State is IDLE, all counters are 0, and row_buf is not cleared (it is overwritten before use).
- Latency: out_valid rises the cycle after the handshake of a window's last pixel. The value holds stable until out_ready.
- Throughput: one input beat per cycle while out_ready is held high.
- Output of the last window and the final input handshake coincide. FLUSH lasts until that output is accepted, which takes at least 1 cycle. done is asserted the cycle after that acceptance, and busy falls in the same cycle.
- Reset mid-frame returns to IDLE immediately and discards all partial results. The next start begins a clean frame.
- Back-to-back frames: start is accepted in the cycle done is high.

## Configuration
- POOL_AVG_EN defined: average datapath compiled in, and mode selects max/avg.
- POOL_AVG_EN undefined: average datapath and wide accumulators omitted. Accumulator width is DATA_WIDTH, mode is ignored, and behaviour is always max.

## Test plan
- 4x4, POOL_SIZE 2, CHANNELS 1, mode 0, input 0..15 raster, out_ready=1 -> outputs 5, 7, 13, 15. done pulses once, 1 cycle after the 4th acceptance.
- Same stimulus, mode 1, POOL_AVG_EN defined -> outputs 2, 4, 10, 12. With the macro undefined -> 5, 7, 13, 15.
- 5x5, input 0..24 -> outputs 6, 8, 16, 18. Column 4 and row 4 are accepted and discarded, and done is still asserted.
- Backpressure: out_ready low for 5 cycles while out_valid=1 -> in_ready stays 0, out_data holds, and there is no loss or duplication.
- CHANNELS 2, ch0 = 0..15, ch1 = 15..0, mode 0 -> ch0 outputs 5, 7, 13, 15; ch1 outputs 15, 13, 7, 5.
- Reset asserted after 6 input beats, then a new start with 0..15 -> outputs 5, 7, 13, 15 with no stale values. All outputs read reset values during reset.
